z16_instr_mem_loader: RTL and testbench
=======================================

# z16_instr_mem_loader

Parametrised, loadable instruction memory for the Z16 core. It replaces the fixed combinational program store with a RAM of `DEPTH` 16-bit words that a byte-serial boot loader fills at run time, for example from a UART receiver. It also provides a registered fetch port with request/valid handshake and address fault reporting. It sits between the boot/debug link and the CPU fetch stage.

## Interface
- `DEPTH`, 256: number of 16-bit instruction words; power of two, 2..32768.
- `NOP_WORD`, 16'h0000: word returned on faulted fetch (ADD ZR ZR ZR).
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_fetch_req` in 1: fetch request, sampled with `i_addr`.
- `i_addr` in 16: byte address of the instruction; word index is `i_addr[15:1]`.
- `o_instr` out 16: fetched instruction.
- `o_valid` out 1: `o_instr` / `o_fault` valid, one-cycle pulse per accepted fetch.
- `o_fault` out 1: fetch was out of range (or misaligned, see Configuration).
- `i_ld_start` in 1: begin a new load session.
- `i_ld_byte_valid` in 1: `i_ld_byte` present.
- `i_ld_byte` in 8: loader data byte.
- `o_ld_ready` out 1: block accepts a byte this cycle.
- `o_ld_busy` out 1: load session in progress; fetches are refused.
- `o_ld_err` out 1: sticky; the header count exceeded `DEPTH`.

## Operation
- FSM states: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI.
- Byte acceptance: a byte is accepted when `i_ld_byte_valid && o_ld_ready`.
- `o_ld_ready`: equals 1 in every state except IDLE. Bytes in IDLE are ignored.
- Stream format: 16-bit word count N, then N words. Every 16-bit field is sent low byte first.
- IDLE: `i_ld_start` moves to LEN_LO, clears the write pointer and clears `o_ld_err`.
- LEN_LO / LEN_HI: capture N.
  - After LEN_HI, if N == 0, return to IDLE.
  - Otherwise go to DAT_LO.
  - If N > DEPTH, set `o_ld_err`.
- DAT_LO: latch the low byte.
- DAT_HI: write the word to `mem[ptr]` if ptr < DEPTH, otherwise drop it. Then increment ptr and the word counter.
  - If the counter reaches N, go to IDLE; else go to DAT_LO.
- `i_ld_start` in any non-IDLE state restarts the session at LEN_LO with ptr = 0. If start and a byte arrive in the same cycle, start wins and the byte is dropped.
- `o_ld_busy` = (state != IDLE).
- Fetch accepted: when `i_fetch_req && !o_ld_busy`.
  - Next cycle `o_valid` = 1 and `o_instr` = `mem[i_addr[15:1]]`.
  - If `i_addr[15:1]` >= DEPTH: `o_instr` = `NOP_WORD` and `o_fault` = 1.
- Fetch refused: when `i_fetch_req` is high while busy, the next cycle has `o_valid` = 0. The CPU must re-request.
- Output hold: `o_instr` and `o_fault` hold their last values when no fetch is accepted. `o_valid` returns to 0.
- Memory contents: not affected by reset. Initialised to `NOP_WORD` at time zero.

## Timing
- Reset values: `o_instr` = 0, `o_valid` = 0, `o_fault` = 0, `o_ld_busy` = 0, `o_ld_err` = 0, state IDLE.
- Fetch latency: exactly 1 cycle. Back-to-back requests give back-to-back valid results.
- Load throughput: one byte per cycle.
- Write completion: a word is written on the edge that accepts its DAT_HI byte.
- Last byte: `o_ld_busy` falls on the edge that accepts the final byte. A fetch in the following cycle is accepted and sees the new contents.
- Reset mid-load: aborts the session; words already written remain.
- Read/write conflict: impossible, because fetch is refused while busy.

## Configuration
- `Z16_IMEM_ALIGN_CHECK_EN` defined: `i_addr[0]` = 1 raises `o_fault`, and `o_instr` = `NOP_WORD`.
- `Z16_IMEM_ALIGN_CHECK_EN` undefined: `i_addr[0]` is ignored and only the range check raises `o_fault`.

## Test plan
- Basic load and fetch: DEPTH=8, stream 02 00 40 00 5D 60 -> busy falls after the 6th byte. Then fetch 0x0000 -> 0x0040 valid at +1; fetch 0x0002 -> 0x605D valid at +1, `o_fault` = 0.
- Out of range: DEPTH=8, fetch 0x0010 -> `o_valid` = 1, `o_instr` = 0x0000, `o_fault` = 1.
- Misaligned: fetch 0x0003 -> with macro, `o_fault` = 1 and 0x0000; without macro, 0x605D and `o_fault` = 0.
- Fetch during load: fetch while busy -> `o_valid` = 0 on the next cycle, `o_instr` unchanged.
- Overflow: DEPTH=8, N=10, 10 words of 0x1100+i -> `o_ld_err` = 1; `mem[7]` = 0x1107; words 8 and 9 dropped; busy falls after 22 bytes.
- Restart and reset: `i_ld_start` plus a byte mid-DAT_LO -> byte dropped, state LEN_LO. Assert `i_rst_n` = 0 mid-load -> all outputs at reset values, previously written words intact on fetch.

Source files
------------

// File: rtl/z16_instr_mem_loader.sv
// z16_instr_mem_loader: byte-serial loadable instruction RAM with fetch port.
// Optional misaligned-fetch fault check: define Z16_IMEM_ALIGN_CHECK_EN.
module z16_instr_mem_loader #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_req,
    input  logic [15:0] i_addr,
    output logic [15:0] o_instr,
    output logic        o_valid,
    output logic        o_fault,
    input  logic        i_ld_start,
    input  logic        i_ld_byte_valid,
    input  logic [7:0]  i_ld_byte,
    output logic        o_ld_ready,
    output logic        o_ld_busy,
    output logic        o_ld_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DAT_LO,
        DAT_HI
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  lo_q, lo_d;
    logic        err_q, err_d;
    logic        we;
    logic        byte_acc;
    logic [15:0] hdr_n;

    logic [15:0] mem_q [DEPTH];

    logic [15:0] instr_q;
    logic        valid_q;
    logic        fault_q;
    logic [14:0] widx;
    logic        fetch_acc;
    logic        range_flt;
    logic        align_flt;
    logic        flt;

    assign o_ld_ready = (state_q != IDLE);
    assign o_ld_busy  = (state_q != IDLE);
    assign o_ld_err   = err_q;
    assign byte_acc   = i_ld_byte_valid && o_ld_ready;
    assign hdr_n      = {i_ld_byte, len_q[7:0]};

    // Loader state, word count, write pointer and error flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // Stream parser: start always wins over a byte arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        err_d   = err_q;
        we      = 1'b0;
        if (i_ld_start) begin
            state_d = LEN_LO;
            ptr_d   = '0;
            err_d   = 1'b0;
        end else if (byte_acc) begin
            unique case (state_q)
                LEN_LO: begin
                    len_d[7:0] = i_ld_byte;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d   = hdr_n;
                    ptr_d   = '0;
                    err_d   = err_q | (hdr_n > DEPTH16);
                    state_d = (hdr_n == 16'd0) ? IDLE : DAT_LO;
                end
                DAT_LO: begin
                    lo_d    = i_ld_byte;
                    state_d = DAT_HI;
                end
                DAT_HI: begin
                    we      = (ptr_q < DEPTH16);
                    ptr_d   = ptr_q + 16'd1;
                    state_d = ((ptr_q + 16'd1) == len_q) ? IDLE : DAT_LO;
                end
                default: ;
            endcase
        end
    end

    // Program RAM; contents survive reset so a reset mid-load keeps written words.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_q[ptr_q[AW-1:0]] <= {i_ld_byte, lo_q};
        end
    end

    assign widx      = i_addr[15:1];
    assign fetch_acc = i_fetch_req && !o_ld_busy;
    assign range_flt = ({1'b0, widx} >= DEPTH16);

`ifdef Z16_IMEM_ALIGN_CHECK_EN
    assign align_flt = i_addr[0];
`else
    logic unused_addr0;
    assign unused_addr0 = i_addr[0];
    assign align_flt    = 1'b0;
`endif

    assign flt = range_flt | align_flt;

    // Registered fetch port: instr/fault hold between accepted fetches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= fetch_acc;
            if (fetch_acc) begin
                instr_q <= flt ? NOP_WORD : mem_q[widx[AW-1:0]];
                fault_q <= flt;
            end
        end
    end

    assign o_instr = instr_q;
    assign o_valid = valid_q;
    assign o_fault = fault_q;

endmodule

// File: tb/tb_z16_instr_mem_loader.sv
// tb_z16_instr_mem_loader: directed plus randomized load/fetch checks
// against a word-level model of the program store (DEPTH = 8).
module tb_z16_instr_mem_loader;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] addr = '0;
    logic        ld_start = 1'b0;
    logic        ld_bv = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic [15:0] o_instr;
    logic        o_valid;
    logic        o_fault;
    logic        o_ld_ready;
    logic        o_ld_busy;
    logic        o_ld_err;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mdl [DEPTH];
    logic [15:0] wq [$];
    logic [15:0] last_instr = '0;
    logic        last_fault = 1'b0;

    z16_instr_mem_loader #(
        .DEPTH(DEPTH),
        .NOP_WORD(16'h0000)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_fetch_req(fetch_req),
        .i_addr(addr),
        .o_instr(o_instr),
        .o_valid(o_valid),
        .o_fault(o_fault),
        .i_ld_start(ld_start),
        .i_ld_byte_valid(ld_bv),
        .i_ld_byte(ld_byte),
        .o_ld_ready(o_ld_ready),
        .o_ld_busy(o_ld_busy),
        .o_ld_err(o_ld_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ld_bv   = 1'b1;
        ld_byte = b;
        tick();
        ld_bv   = 1'b0;
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // Expected result from the word-level rules, then one request cycle.
    task automatic fetch(input logic [15:0] a, input string tag);
        int          w;
        logic        ef;
        logic [15:0] ei;
        w  = int'(a >> 1);
        ef = (w >= DEPTH);
`ifdef Z16_IMEM_ALIGN_CHECK_EN
        if (a[0]) ef = 1'b1;
`endif
        if (ef) ei = 16'h0000;
        else    ei = mdl[w];
        fetch_req = 1'b1;
        addr      = a;
        tick();
        fetch_req = 1'b0;
        chk({tag, ".valid"}, 16'(o_valid), 16'd1);
        chk({tag, ".instr"}, o_instr, ei);
        chk({tag, ".fault"}, 16'(o_fault), 16'(ef));
        last_instr = ei;
        last_fault = ef;
    endtask

    // Whole session: header N, then N words from wq; words past DEPTH dropped.
    task automatic load(input int n, input string tag);
        logic [15:0] nn;
        nn = 16'(n);
        start();
        chk({tag, ".busy0"}, 16'(o_ld_busy), 16'd1);
        chk({tag, ".rdy"}, 16'(o_ld_ready), 16'd1);
        send(nn[7:0]);
        send(nn[15:8]);
        chk({tag, ".err"}, 16'(o_ld_err), 16'(n > DEPTH));
        for (int i = 0; i < n; i++) begin
            send(wq[i][7:0]);
            chk({tag, ".busyw"}, 16'(o_ld_busy), 16'd1);
            send(wq[i][15:8]);
            if (i < DEPTH) mdl[i] = wq[i];
        end
        chk({tag, ".busy_end"}, 16'(o_ld_busy), 16'd0);
        chk({tag, ".err_end"}, 16'(o_ld_err), 16'(n > DEPTH));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".instr"}, o_instr, 16'h0000);
        chk({tag, ".valid"}, 16'(o_valid), 16'd0);
        chk({tag, ".fault"}, 16'(o_fault), 16'd0);
        chk({tag, ".busy"}, 16'(o_ld_busy), 16'd0);
        chk({tag, ".err"}, 16'(o_ld_err), 16'd0);
        chk({tag, ".rdy"}, 16'(o_ld_ready), 16'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;

        // Reset state
        tick();
        tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        send(8'hAA);
        chk("idle_byte.busy", 16'(o_ld_busy), 16'd0);

        // Empty session returns to idle after the header
        wq = {};
        load(0, "n0");

        // Basic: 02 00 40 00 5D 60
        wq = {16'h0040, 16'h605D};
        load(2, "basic");
        fetch(16'h0000, "f0");
        fetch(16'h0002, "f2");
        tick();
        chk("hold.valid", 16'(o_valid), 16'd0);
        chk("hold.instr", o_instr, last_instr);

        // Out of range and misaligned
        fetch(16'h0010, "oor");
        fetch(16'h0003, "mis");
        fetch(16'hFFFE, "oor_top");

        // Full random load at exactly DEPTH words, then random fetches
        wq = {};
        for (int i = 0; i < DEPTH; i++) wq.push_back(16'($urandom));
        load(DEPTH, "full");
        for (int k = 0; k < 24; k++) begin
            fetch(16'($urandom_range(0, 31)), "rnd");
        end

        // Fetch refused while busy
        start();
        send(8'h01);
        send(8'h00);
        fetch_req = 1'b1;
        addr      = 16'h0000;
        tick();
        fetch_req = 1'b0;
        chk("busy_fetch.valid", 16'(o_valid), 16'd0);
        chk("busy_fetch.instr", o_instr, last_instr);
        chk("busy_fetch.fault", 16'(o_fault), 16'(last_fault));
        send(8'h34);
        send(8'h12);
        mdl[0] = 16'h1234;
        chk("busy_fetch.busy", 16'(o_ld_busy), 16'd0);
        fetch(16'h0000, "after_busy");

        // Overflow: N = 10
        wq = {};
        for (int i = 0; i < 10; i++) wq.push_back(16'h1100 + 16'(i));
        load(10, "ovf");
        fetch(16'h000E, "ovf7");
        fetch(16'h0000, "ovf0");
        fetch(16'h0010, "ovf8");

        // Restart with a simultaneous byte mid-DAT_LO
        start();
        send(8'h02);
        send(8'h00);
        ld_start = 1'b1;
        ld_bv    = 1'b1;
        ld_byte  = 8'h55;
        tick();
        ld_start = 1'b0;
        ld_bv    = 1'b0;
        chk("rst_ld.busy", 16'(o_ld_busy), 16'd1);
        chk("rst_ld.err", 16'(o_ld_err), 16'd0);
        send(8'h01);
        send(8'h00);
        send(8'hEF);
        send(8'hBE);
        mdl[0] = 16'hBEEF;
        chk("rst_ld.done", 16'(o_ld_busy), 16'd0);
        fetch(16'h0000, "rst_ld.f0");

        // Reset mid-load
        start();
        send(8'h03);
        send(8'h00);
        send(8'hFE);
        send(8'hCA);
        mdl[0] = 16'hCAFE;
        send(8'h77);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst.busy", 16'(o_ld_busy), 16'd0);
        fetch(16'h0000, "midrst.f0");
        fetch(16'h0002, "midrst.f1");
        fetch(16'h000E, "midrst.f7");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
